// File: rtl/secded_encoder_pipe.sv
// Elastic Hsiao SECDED encoder with a valid/ready handshake, a 1- or 2-stage
// pipeline, per-beat error injection and a delivered-codeword counter.
module secded_encoder_pipe #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CHK_W  = 8,
    parameter int unsigned PIPE   = 2
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       I_VALID,
    output logic                       I_READY,
    input  logic [DATA_W-1:0]          I_DATA,
    input  logic [DATA_W+CHK_W-1:0]    I_INJ,
    output logic                       O_VALID,
    input  logic                       O_READY,
    output logic [DATA_W+CHK_W-1:0]    O_DATA,
    output logic [31:0]                O_CNT
);

    localparam int unsigned CW = DATA_W + CHK_W;

    // Number of available odd-weight columns (weights 3 and 5).
    function automatic int unsigned num_cols();
        int unsigned n;
        n = 0;
        for (int v = 0; v < (1 << CHK_W); v++) begin
            if ($countones(v) == 3 || $countones(v) == 5) n++;
        end
        return n;
    endfunction

    // Columns are assigned in ascending integer order: all weight-3 values, then weight-5.
    // Data is consumed LSB first by shifting a local copy.
    function automatic logic [CHK_W-1:0] calc_check(input logic [DATA_W-1:0] d);
        logic [CHK_W-1:0]  c;
        logic [DATA_W-1:0] dd;
        int unsigned       k;
        c  = '0;
        dd = d;
        k  = 0;
        for (int w = 3; w <= 5; w += 2) begin
            for (int v = 0; v < (1 << CHK_W); v++) begin
                if ($countones(v) == w && k < DATA_W) begin
                    if (dd[0]) c ^= v[CHK_W-1:0];
                    dd = dd >> 1;
                    k++;
                end
            end
        end
        return c;
    endfunction

    if (num_cols() < DATA_W) begin : g_bad_chk
        $error("CHK_W too small: not enough odd-weight columns for DATA_W");
    end

    logic        o_fire;
    logic [31:0] cnt_q, cnt_d;

    if (PIPE == 1) begin : g_pipe1
        logic          v1_q, v1_d;
        logic          in_fire;
        logic [CW-1:0] odata_q, odata_d;

        // Single stage: load when empty or draining this cycle.
        always_comb begin
            I_READY = ~v1_q | O_READY;
            in_fire = I_VALID & I_READY;
            v1_d    = in_fire | (v1_q & ~O_READY);
            odata_d = odata_q;
            if (in_fire) odata_d = {calc_check(I_DATA), I_DATA} ^ I_INJ;
        end

        // Stage register with reset of valid and output data.
        always_ff @(posedge CLK) begin
            if (RST) begin
                v1_q    <= 1'b0;
                odata_q <= '0;
            end else begin
                v1_q    <= v1_d;
                odata_q <= odata_d;
            end
        end

        assign O_VALID = v1_q;
        assign O_DATA  = odata_q;
    end else if (PIPE == 2) begin : g_pipe2
        logic              v1_q, v1_d;
        logic              v2_q, v2_d;
        logic              ld2;
        logic              in_fire;
        logic [DATA_W-1:0] d1_q;
        logic [CW-1:0]     inj1_q;
        logic [CW-1:0]     odata_q, odata_d;

        // Stage 2 loads when empty or draining; stage 1 frees up when it moves into stage 2.
        always_comb begin
            ld2     = v1_q & (~v2_q | O_READY);
            I_READY = ~v1_q | ld2;
            in_fire = I_VALID & I_READY;
            v1_d    = in_fire | (v1_q & ~ld2);
            v2_d    = ld2 | (v2_q & ~O_READY);
            odata_d = odata_q;
            if (ld2) odata_d = {calc_check(d1_q), d1_q} ^ inj1_q;
        end

        // Valid bits and output codeword register.
        always_ff @(posedge CLK) begin
            if (RST) begin
                v1_q    <= 1'b0;
                v2_q    <= 1'b0;
                odata_q <= '0;
            end else begin
                v1_q    <= v1_d;
                v2_q    <= v2_d;
                odata_q <= odata_d;
            end
        end

        // Stage-1 payload; only ever forwarded while v1_q is set, so no reset needed.
        always_ff @(posedge CLK) begin
            if (in_fire) begin
                d1_q   <= I_DATA;
                inj1_q <= I_INJ;
            end
        end

        assign O_VALID = v2_q;
        assign O_DATA  = odata_q;
    end else begin : g_bad_pipe
        $error("PIPE must be 1 or 2");
        assign I_READY = 1'b0;
        assign O_VALID = 1'b0;
        assign O_DATA  = '0;
    end

    // Delivered-codeword counter, wraps naturally.
    always_comb begin
        o_fire = O_VALID & O_READY;
        cnt_d  = cnt_q;
        if (o_fire) cnt_d = cnt_q + 32'd1;
    end

    // Counter register.
    always_ff @(posedge CLK) begin
        if (RST) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign O_CNT = cnt_q;

endmodule

// File: tb/tb_secded_encoder_pipe.sv
// Scoreboard bench: unit 0 is PIPE=2, unit 1 is PIPE=1. Stimulus pushes the
// expected codeword on each input transfer; a monitor pops on each output transfer.
module tb_secded_encoder_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        iv   [2];
    logic        ird  [2];
    logic        ov   [2];
    logic        ordy [2];
    logic [63:0] id   [2];
    logic [71:0] inj  [2];
    logic [71:0] od   [2];
    logic [31:0] cnt  [2];

    int checks = 0;
    int errors = 0;
    int exp_cnt [2];
    logic [71:0] sb0[$];
    logic [71:0] sb1[$];
    logic [7:0]  cols[64];
    logic        stop;

    always #5 clk = ~clk;

    secded_encoder_pipe #(.DATA_W(64), .CHK_W(8), .PIPE(2)) u_p2 (
        .CLK(clk), .RST(rst), .I_VALID(iv[0]), .I_READY(ird[0]), .I_DATA(id[0]),
        .I_INJ(inj[0]), .O_VALID(ov[0]), .O_READY(ordy[0]), .O_DATA(od[0]), .O_CNT(cnt[0])
    );

    secded_encoder_pipe #(.DATA_W(64), .CHK_W(8), .PIPE(1)) u_p1 (
        .CLK(clk), .RST(rst), .I_VALID(iv[1]), .I_READY(ird[1]), .I_DATA(id[1]),
        .I_INJ(inj[1]), .O_VALID(ov[1]), .O_READY(ordy[1]), .O_DATA(od[1]), .O_CNT(cnt[1])
    );

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int qsize(input int u);
        return (u == 0) ? sb0.size() : sb1.size();
    endfunction

    // Reference check bits from the column table.
    function automatic logic [7:0] ref_chk(input logic [63:0] d);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 0; i < 64; i++) if (d[i]) c ^= cols[i];
        return c;
    endfunction

    // Present one beat and hold it until accepted (bounded).
    task automatic send(input int u, input logic [63:0] d, input logic [71:0] m,
                        input logic [71:0] e, output int waits);
        bit ok;
        waits = 0;
        ok    = 1'b0;
        iv[u]  = 1'b1;
        id[u]  = d;
        inj[u] = m;
        while (!ok && waits <= 40) begin
            @(negedge clk);
            if (ird[u]) ok = 1'b1;
            else begin
                waits++;
                tick();
            end
        end
        if (ok) begin
            if (u == 0) sb0.push_back(e);
            else        sb1.push_back(e);
            exp_cnt[u]++;
            tick();
        end else begin
            checks++;
            errors++;
            $display("FAIL send_timeout unit%0d: got I_READY=0 for %0d cycles expected 1", u, waits);
        end
        iv[u] = 1'b0;
    endtask

    // Wait for the scoreboard to empty, then compare the delivered count.
    task automatic drain(input int u, input string name);
        int n;
        n = 0;
        while (qsize(u) != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (qsize(u) != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_drain: got %0d pending expected 0", name, qsize(u));
        end
        tick();
        tick();
        chk(name, {40'h0, cnt[u]}, exp_cnt[u]);
    endtask

    task automatic feed(input int u, input int n);
        int          w;
        logic [63:0] d;
        logic [71:0] m;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 2)) tick();
            d = {$urandom, $urandom};
            m = '0;
            if ($urandom_range(0, 3) == 0) m[$urandom_range(0, 71)] = 1'b1;
            send(u, d, m, {ref_chk(d), d} ^ m, w);
        end
    endtask

    // Output monitor.
    always @(negedge clk) begin
        if (!rst) begin
            if (ov[0] && ordy[0]) begin
                if (sb0.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_out0: got %h expected no output", od[0]);
                end else chk("out_p2", od[0], sb0.pop_front());
            end
            if (ov[1] && ordy[1]) begin
                if (sb1.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_out1: got %h expected no output", od[1]);
                end else chk("out_p1", od[1], sb1.pop_front());
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    logic [7:0]  tab4 [10];
    logic [71:0] held;
    int          w;

    initial begin
        int k;
        k = 0;
        for (int wt = 3; wt <= 5; wt += 2)
            for (int v = 0; v < 256; v++)
                if ($countones(v) == wt && k < 64) begin
                    cols[k] = v[7:0];
                    k++;
                end
        tab4 = '{8'h00, 8'h07, 8'h0B, 8'h0C, 8'h0D, 8'h0A, 8'h06, 8'h01, 8'h0E, 8'h09};
        for (int u = 0; u < 2; u++) begin
            iv[u] = 1'b0; ordy[u] = 1'b1; id[u] = '0; inj[u] = '0; exp_cnt[u] = 0;
        end
        stop = 1'b0;

        // Reset state.
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            chk("rst_ovalid", ov[u], 0);
            chk("rst_cnt", cnt[u], 0);
            chk("rst_odata", od[u], 0);
            chk("rst_iready", ird[u], 1);
        end
        tick();

        // Single beat, latency 2.
        send(0, 64'h1, '0, 72'h07_0000000000000001, w);
        @(negedge clk);
        chk("lat2_early", ov[0], 0);
        tick();
        @(negedge clk);
        chk("lat2_valid", ov[0], 1);
        chk("lat2_data", od[0], 72'h07_0000000000000001);
        tick();
        drain(0, "cnt_single");

        // Back-to-back, no bubbles.
        send(0, 64'h0, '0, 72'h00_0000000000000000, w);
        chk("b2b_wait0", w, 0);
        send(0, 64'h2, '0, 72'h0B_0000000000000002, w);
        chk("b2b_wait1", w, 0);
        send(0, 64'h3, '0, 72'h0C_0000000000000003, w);
        chk("b2b_wait2", w, 0);
        @(negedge clk);
        chk("b2b_v1", ov[0], 1);
        tick();
        @(negedge clk);
        chk("b2b_v2", ov[0], 1);
        chk("b2b_d2", od[0], 72'h0C_0000000000000003);
        tick();
        @(negedge clk);
        chk("b2b_done", ov[0], 0);
        tick();
        drain(0, "cnt_b2b");

        // PIPE=1: latency 1 and back-to-back.
        send(1, 64'h1, '0, 72'h07_0000000000000001, w);
        @(negedge clk);
        chk("lat1_valid", ov[1], 1);
        tick();
        send(1, 64'h0, '0, 72'h00_0000000000000000, w);
        chk("p1_wait0", w, 0);
        send(1, 64'h2, '0, 72'h0B_0000000000000002, w);
        chk("p1_wait1", w, 0);
        send(1, 64'h3, '0, 72'h0C_0000000000000003, w);
        chk("p1_wait2", w, 0);
        drain(1, "cnt_p1");

        // Stream of 10 with a mid-stream stall.
        fork
            begin
                int ww;
                for (int i = 0; i < 10; i++)
                    send(0, 64'(i), '0, {tab4[i], 64'(i)}, ww);
            end
            begin
                repeat (3) tick();
                ordy[0] = 1'b0;
                tick();
                tick();
                @(negedge clk);
                chk("stall_iready", ird[0], 0);
                chk("stall_ovalid", ov[0], 1);
                held = od[0];
                repeat (2) begin
                    tick();
                    @(negedge clk);
                    chk("stall_hold", od[0], held);
                end
                tick();
                ordy[0] = 1'b1;
            end
        join
        drain(0, "cnt_stream");

        // Error injection.
        send(0, 64'h0, 72'h1, 72'h00_0000000000000001, w);
        send(0, 64'h0, 72'h01_0000000000000000, 72'h01_0000000000000000, w);
        drain(0, "cnt_inj");

        // Reset with beats in flight.
        ordy[0] = 1'b0;
        send(0, 64'h5, '0, 72'h0A_0000000000000005, w);
        send(0, 64'h6, '0, 72'h06_0000000000000006, w);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_ovalid", ov[0], 0);
        chk("mid_rst_cnt", cnt[0], 0);
        chk("mid_rst_iready", ird[0], 1);
        sb0.delete();
        sb1.delete();
        exp_cnt[0] = 0;
        exp_cnt[1] = 0;
        tick();
        ordy[0] = 1'b1;
        send(0, 64'h4, '0, 72'h0D_0000000000000004, w);
        @(negedge clk);
        chk("post_rst_early", ov[0], 0);
        tick();
        @(negedge clk);
        chk("post_rst_valid", ov[0], 1);
        chk("post_rst_data", od[0], 72'h0D_0000000000000004);
        tick();
        drain(0, "cnt_post_rst");
        drain(1, "cnt_p1_rst");

        // Random data, random valid gaps and backpressure on both configurations.
        fork
            begin
                fork
                    feed(0, 30);
                    feed(1, 30);
                join
                stop = 1'b1;
            end
            begin
                while (!stop) begin
                    ordy[0] = 1'($urandom_range(0, 1));
                    ordy[1] = 1'($urandom_range(0, 1));
                    tick();
                end
                ordy[0] = 1'b1;
                ordy[1] = 1'b1;
            end
        join
        drain(0, "cnt_rand_p2");
        drain(1, "cnt_rand_p1");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
